// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 constants, FSM states and special-case codes for the FPU
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W = FRAC_W + 1;
    localparam int BIAS = 127;
    localparam logic [8:0] EXP_INF = 9'd255;
    localparam logic [48:0] QNAN_MAN = 49'h0_4000_0000_0000;
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;
endpackage

// File: rtl/fp_mul_core_if.sv
// fp_mul_core_if: operand/start request and normalized result bundle of the multiplier
interface fp_mul_core_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        normalized_result_sign;
    logic [8:0]  normalized_result_exp;
    logic [48:0] normalized_result_man;
    logic        done_cal;
    modport master (
        output start, op_a, op_b,
        input  busy, normalized_result_sign, normalized_result_exp, normalized_result_man, done_cal
    );
    modport slave (
        input  start, op_a, op_b,
        output busy, normalized_result_sign, normalized_result_exp, normalized_result_man, done_cal
    );
endinterface

// File: rtl/fp_sig_mult_seq.sv
// fp_sig_mult_seq: 24x24 shift-add significand multiplier, one multiplier bit per cycle
module fp_sig_mult_seq
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SIG_W-1:0]   a,
    input  logic [SIG_W-1:0]   b,
    output logic               done,
    output logic [2*SIG_W-1:0] product
);
    logic [2*SIG_W-1:0] acc;
    logic [2*SIG_W-1:0] mcand;
    logic [SIG_W-1:0]   mplier;
    logic [4:0]         cnt;
    logic               run;

    // done flags the cycle whose closing edge performs the last iteration
    assign done = run && cnt == 5'(SIG_W - 1);
    assign product = acc;

    // load on start, then add the shifted multiplicand when the multiplier LSB is set
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            acc <= '0;
            mcand <= {{SIG_W{1'b0}}, a};
            mplier <= b;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= acc + (mplier[0] ? mcand : '0);
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 5'd1;
            run <= !done;
        end
    end
endmodule

// File: rtl/fp_mul_core.sv
// fp_mul_core: binary32 multiply front-end producing sign, biased exponent and normalized significand
module fp_mul_core
    import fpu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    fp_mul_core_if.slave bus
);
    state_t   state;
    special_t sp, sp_in;
    logic [EXP_W-1:0] ea, eb;
    logic sgn;
    logic a_top, b_top, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic mul_start, mul_done;
    logic [47:0] prod;
    logic [9:0]  e_sum;
    logic e_ovf, e_unf;
    logic [48:0] nrm_man;

    assign a_top = &bus.op_a[30:FRAC_W];
    assign b_top = &bus.op_b[30:FRAC_W];
    assign a_zero = bus.op_a[30:FRAC_W] == '0;
    assign b_zero = bus.op_b[30:FRAC_W] == '0;
    assign a_nan = a_top && |bus.op_a[FRAC_W-1:0];
    assign b_nan = b_top && |bus.op_b[FRAC_W-1:0];
    assign a_inf = a_top && !(|bus.op_a[FRAC_W-1:0]);
    assign b_inf = b_top && !(|bus.op_b[FRAC_W-1:0]);
    assign sp_in = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? SP_NAN :
                   (a_inf || b_inf) ? SP_INF :
                   (a_zero || b_zero) ? SP_ZERO : SP_NONE;
    assign mul_start = state == IDLE && bus.start && sp_in == SP_NONE;

    fp_sig_mult_seq u_mult (
        .clk(clk),
        .rst(rst),
        .start(mul_start),
        .a({1'b1, bus.op_a[FRAC_W-1:0]}),
        .b({1'b1, bus.op_b[FRAC_W-1:0]}),
        .done(mul_done),
        .product(prod)
    );

    // exponent as 10-bit two's complement so underflow shows up as a set sign bit
    assign e_sum = {2'b0, ea} + {2'b0, eb} - 10'(BIAS) + {9'b0, prod[47]};
    assign e_ovf = !e_sum[9] && e_sum >= 10'd255;
    assign e_unf = e_sum[9] || e_sum == '0;
    assign nrm_man = prod[47] ? {1'b0, prod} : {1'b0, prod[46:0], 1'b0};

    // control FSM; results are written only in NORM and held until the next NORM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sp <= SP_NONE;
            ea <= '0;
            eb <= '0;
            sgn <= 1'b0;
            bus.busy <= 1'b0;
            bus.done_cal <= 1'b0;
            bus.normalized_result_sign <= 1'b0;
            bus.normalized_result_exp <= '0;
            bus.normalized_result_man <= '0;
        end else begin
            bus.done_cal <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sgn <= bus.op_a[31] ^ bus.op_b[31];
                    ea <= bus.op_a[30:FRAC_W];
                    eb <= bus.op_b[30:FRAC_W];
                    sp <= sp_in;
                    bus.busy <= 1'b1;
                    state <= sp_in == SP_NONE ? MUL : NORM;
                end
                MUL: if (mul_done) state <= NORM;
                NORM: begin
                    bus.normalized_result_sign <= sp == SP_NAN ? 1'b0 : sgn;
                    bus.normalized_result_exp <= (sp == SP_NAN || sp == SP_INF) ? EXP_INF :
                                                 sp == SP_ZERO ? 9'd0 :
                                                 e_ovf ? EXP_INF : e_unf ? 9'd0 : e_sum[8:0];
                    bus.normalized_result_man <= sp == SP_NAN ? QNAN_MAN :
                                                 (sp != SP_NONE || e_ovf || e_unf) ? 49'd0 : nrm_man;
                    state <= DONE;
                end
                DONE: begin
                    bus.done_cal <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
